uart_rx_param: RTL

//  Parametrised UART receiver for the FPGA host link: 1 start, DATA_BITS data (LSB first), optional parity, 1-2 stop.

---
 rtl/uart_rx_param.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// UART receiver: run-time baud divisor, 3-sample majority vote, frame/parity/overrun flags,
// one-deep valid/ready output buffer. Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned DIV_W     = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 Rx_in,
   input  logic [DIV_W-1:0]     Clks_Per_Bit_in,
   input  logic [1:0]           Parity_Mode_in,
   output logic [DATA_BITS-1:0] Rx_Data_out,
   output logic                 Rx_Valid_out,
   input  logic                 Rx_Ready_in,
   output logic                 Rx_Frame_Err_out,
   output logic                 Rx_Parity_Err_out,
   output logic                 Rx_Overrun_out
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic                 rx_s1, rx_s2;
   logic [2:0]           vote_sr;
   logic                 vote_c;

   logic [2:0]           state_q, state_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 last_cnt_c;
   logic [DIV_W-1:0]     half_c;

`ifdef UART_RX_PARITY_EN
   logic [1:0]           pmode_q, pmode_d;
`else
   logic                 unused_pmode;
   assign unused_pmode = ^Parity_Mode_in;
`endif

   // Synchroniser and majority-vote window; idle-high after reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         vote_sr <= 3'b111;
      end else begin
         rx_s1   <= Rx_in;
         rx_s2   <= rx_s1;
         vote_sr <= {vote_sr[1:0], rx_s2};
      end
   end

   assign vote_c     = (vote_sr[0] & vote_sr[1]) | (vote_sr[0] & vote_sr[2]) | (vote_sr[1] & vote_sr[2]);
   assign last_cnt_c = (cnt_q == (div_q - DIV_W'(1)));
   assign half_c     = (div_q - DIV_W'(1)) >> 1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         div_q      <= DIV_MIN;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shreg_q    <= '0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pmode_q    <= 2'b00;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shreg_q    <= shreg_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
`ifdef UART_RX_PARITY_EN
         pmode_q    <= pmode_d;
`endif
      end
   end

   // Frame sequencing; all timing is measured from the synchronised start edge
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shreg_d    = shreg_q;
      ferr_d     = ferr_q;
      perr_d     = perr_q;
`ifdef UART_RX_PARITY_EN
      pmode_d    = pmode_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_s2) begin
               state_d = S_START;
               cnt_d   = '0;
               div_d   = (Clks_Per_Bit_in < DIV_MIN) ? DIV_MIN : Clks_Per_Bit_in;
               ferr_d  = 1'b0;
               perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
               pmode_d = Parity_Mode_in;
`endif
            end
         end
         S_START: begin
            if (cnt_q == half_c) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = vote_c ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (last_cnt_c) begin
               cnt_d     = '0;
               shreg_d   = {vote_c, shreg_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + IDX_W'(1);
               if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                  stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                  state_d = (pmode_q == 2'b01 || pmode_q == 2'b10) ? S_PARITY : S_STOP;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (last_cnt_c) begin
               cnt_d   = '0;
               perr_d  = ((^shreg_q) ^ vote_c) != (pmode_q == 2'b01);
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (last_cnt_c) begin
               cnt_d = '0;
               if (!vote_c) ferr_d = 1'b1;
               if (stop_idx_q == 1'(STOP_BITS - 1)) state_d = S_DONE;
               else                                 stop_idx_d = stop_idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One-deep output buffer; a same-edge accept frees the slot for the new frame
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Rx_Data_out       <= '0;
         Rx_Valid_out      <= 1'b0;
         Rx_Frame_Err_out  <= 1'b0;
         Rx_Parity_Err_out <= 1'b0;
         Rx_Overrun_out    <= 1'b0;
      end else begin
         Rx_Overrun_out <= 1'b0;
         if (state_q == S_DONE) begin
            if (!Rx_Valid_out || Rx_Ready_in) begin
               Rx_Data_out       <= shreg_q;
               Rx_Frame_Err_out  <= ferr_q;
               Rx_Parity_Err_out <= perr_q;
               Rx_Valid_out      <= 1'b1;
            end else begin
               Rx_Overrun_out <= 1'b1;
            end
         end else if (Rx_Valid_out && Rx_Ready_in) begin
            Rx_Valid_out <= 1'b0;
         end
      end
   end

endmodule
